// File: rtl/prv664_pkg.sv
// Shared prv664 types: the fetch group carried from fetch to decode.
`include "prv664_config.svh"

package prv664_pkg;

  localparam int XLEN = `XLEN;

  typedef struct packed {
    logic [XLEN-1:0] grouppc;
    logic [127:0]    instr;
    logic [3:0]      validword;
  } fetch_group_t;

  // A group with no valid word carries no work for decode.
  function automatic logic fg_has_work(input logic [3:0] validword);
    return (validword != 4'b0000);
  endfunction

endpackage

// File: rtl/pip_flush_interface.sv
// Pipeline flush broadcast.
interface pip_flush_interface;
  logic flush;

  modport master (output flush);
  modport slave  (input flush);
endinterface

// File: rtl/pip_ifu_interface.sv
// Valid/ready link carrying one fetch group per handshake.
interface pip_ifu_interface;
  import prv664_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] grouppc;
  logic [127:0]    instr;
  logic [3:0]      validword;

  modport master (output valid, grouppc, instr, validword, input ready);
  modport slave  (input valid, grouppc, instr, validword, output ready);
endinterface

// File: rtl/fetch_group_queue_fifo_ptr_ctrl.sv
// Pointer/count bookkeeping for the fetch group queue, with flush clearing all state.
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          i_flush,
  input  logic          i_push_valid,
  input  logic          i_push_keep,
  input  logic          i_pop_ready,
  output logic          o_push_ready,
  output logic          o_pop_valid,
  output logic          o_wr_en,
  output logic [PW-1:0] o_wp,
  output logic [PW-1:0] o_rp,
  output logic [CW-1:0] o_cnt
);

  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_wp_nxt;
  logic [PW-1:0] w_rp_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full       = (r_cnt == CW'(DEPTH));
  assign o_push_ready = ~i_flush & ~w_full;
  assign o_pop_valid  = ~i_flush & (r_cnt != '0);
  // Zero-validword groups complete the handshake but never occupy a slot.
  assign w_push       = i_push_valid & o_push_ready & i_push_keep;
  assign w_pop        = o_pop_valid & i_pop_ready;

  always_comb begin
    w_wp_nxt  = r_wp;
    w_rp_nxt  = r_rp;
    w_cnt_nxt = r_cnt;
    if (i_flush) begin
      w_wp_nxt  = '0;
      w_rp_nxt  = '0;
      w_cnt_nxt = '0;
    end else begin
      w_wp_nxt  = r_wp + PW'(w_push);
      w_rp_nxt  = r_rp + PW'(w_pop);
      w_cnt_nxt = r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_wp_nxt;
      r_rp  <= w_rp_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_wr_en = w_push;
  assign o_wp    = r_wp;
  assign o_rp    = r_rp;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/prv664_config.svh
// Core-wide configuration macros shared by the prv664 pipeline sources.
`ifndef PRV664_CONFIG_SVH
`define PRV664_CONFIG_SVH
`define XLEN 64
`endif

// File: rtl/fetch_group_queue.sv
// Decoupling FIFO of whole fetch groups between fetch and decode.
module fetch_group_queue
  import prv664_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  pip_ifu_interface.slave        ifu_sif,
  pip_ifu_interface.master       decode_mif,
  pip_flush_interface.slave      pip_flush_sif,
  output logic [$clog2(DEPTH):0] occupancy_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_group_t  r_mem [DEPTH];
  fetch_group_t  w_in_group;
  fetch_group_t  w_rd_group;
  logic          w_wr_en;
  logic [PW-1:0] w_wp;
  logic [PW-1:0] w_rp;
  logic [CW-1:0] w_cnt;

  assign w_in_group.grouppc   = ifu_sif.grouppc;
  assign w_in_group.instr     = ifu_sif.instr;
  assign w_in_group.validword = ifu_sif.validword;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk_i        (clk_i),
    .srst_i       (srst_i),
    .i_flush      (pip_flush_sif.flush),
    .i_push_valid (ifu_sif.valid),
    .i_push_keep  (fg_has_work(ifu_sif.validword)),
    .i_pop_ready  (decode_mif.ready),
    .o_push_ready (ifu_sif.ready),
    .o_pop_valid  (decode_mif.valid),
    .o_wr_en      (w_wr_en),
    .o_wp         (w_wp),
    .o_rp         (w_rp),
    .o_cnt        (w_cnt)
  );

  // Storage is deliberately not reset; only the pointers define what is live.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[w_wp] <= w_in_group;
    end
  end

  assign w_rd_group           = r_mem[w_rp];
  assign decode_mif.grouppc   = w_rd_group.grouppc;
  assign decode_mif.instr     = w_rd_group.instr;
  assign decode_mif.validword = w_rd_group.validword;

  assign occupancy_o = w_cnt;
  assign empty_o     = (w_cnt == '0);

endmodule
